dbg_mem_loader: RTL and testbench

Byte-stream debug loader that halts the vexriscv core, programs and reads back RAM, MMIO and ROM through the SoC debug memory port, then releases the core. It sits between the debug UART byte interface and the `dbg_*` memory port plus `cpu_n_reset` of the SoC. It replaces testbench-side `force` sequences with a hardware command engine that supports auto-incrementing bursts, read-back, inactivity timeout and configurable data width and memory-op timing.

---
 rtl/dbg_loader_pkg.sv | 24 ++
 rtl/dbg_byte_shift.sv | 52 +++++
 rtl/dbg_mem_loader.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_dbg_mem_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_loader_pkg.sv
// Shared definitions for the debug memory loader: command opcodes, reply codes
// and the command FSM state encoding.
package dbg_loader_pkg;

    localparam logic [7:0] OP_HALT  = 8'h48;
    localparam logic [7:0] OP_GO    = 8'h47;
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_CNT,
        ST_DATA,
        ST_WRITE,
        ST_READ,
        ST_SEND,
        ST_REPLY
    } state_e;

endpackage

// File: rtl/dbg_byte_shift.sv
// NB-byte little-endian shift register: assembles incoming words byte by byte
// and serialises loaded words LSB first, with a wrapping byte counter.
module dbg_byte_shift #(
    parameter int NB = 4
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            clr_i,
    input  logic            load_i,
    input  logic [NB*8-1:0] load_data_i,
    input  logic            shift_in_i,
    input  logic [7:0]      byte_i,
    input  logic            shift_out_i,
    output logic [NB*8-1:0] word_o,
    output logic [7:0]      byte_o,
    output logic            last_o,
    output logic            zero_o
);

    localparam int W  = NB * 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [W-1:0]  word_q;
    logic [CW-1:0] cnt_q;

    assign last_o = (cnt_q == CW'(NB - 1));
    assign zero_o = (cnt_q == '0);
    assign word_o = word_q;
    assign byte_o = word_q[7:0];

    // NOTE: reset is sampled on the clock edge only, so it sits inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            cnt_q  <= '0;
        end else if (load_i) begin
            word_q <= load_data_i;
            cnt_q  <= '0;
        end else if (shift_in_i) begin
            // New byte enters at the top so the first byte received ends up as the LSB.
            word_q <= W'({byte_i, word_q} >> 8);
            cnt_q  <= last_o ? '0 : cnt_q + CW'(1);
        end else if (shift_out_i) begin
            word_q <= word_q >> 8;
            cnt_q  <= last_o ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/dbg_mem_loader.sv
// Byte-stream debug loader: halts/releases the core and performs burst writes
// and reads on the SoC debug memory port under control of UART commands.
module dbg_mem_loader
    import dbg_loader_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADR_W       = 32,
    parameter int ADR_BYTES   = 4,
    parameter int WR_HOLD     = 1,
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT     = 65535,
    parameter int BOOT_HALTED = 1
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                cpu_n_reset,
    output logic                dbg_mem_op,
    output logic [DATA_W/8-1:0] dbg_wren,
    output logic [ADR_W-1:0]    dbg_adr,
    output logic [DATA_W-1:0]   dbg_do,
    input  logic [DATA_W-1:0]   dbg_di
);

    localparam int NB = DATA_W / 8;
    localparam int AB = ADR_BYTES * 8;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e            state_q, state_d;
    logic [AB-1:0]     adr_q, adr_d;
    logic [7:0]        hdr_q, hdr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              is_wr_q, is_wr_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [15:0]       tim_q, tim_d;
    logic              cpu_n_reset_q, cpu_n_reset_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        reply_q, reply_d;
    logic              mem_op_q, mem_op_d;
    logic [NB-1:0]     wren_q, wren_d;
    logic [ADR_W-1:0]  dbg_adr_q, dbg_adr_d;

    logic              sh_clr, sh_load, sh_in, sh_out;
    logic [DATA_W-1:0] sh_word;
    logic [7:0]        sh_byte;
    logic              sh_last, sh_zero;

    logic              rx_fire, tmo_hit;
    logic [AB-1:0]     adr_nxt;

    dbg_byte_shift #(.NB(NB)) u_shift (
        .clk         (clk),
        .n_reset     (n_reset),
        .clr_i       (sh_clr),
        .load_i      (sh_load),
        .load_data_i (dbg_di),
        .shift_in_i  (sh_in),
        .byte_i      (rx_data),
        .shift_out_i (sh_out),
        .word_o      (sh_word),
        .byte_o      (sh_byte),
        .last_o      (sh_last),
        .zero_o      (sh_zero)
    );

    assign rx_ready    = (state_q == ST_IDLE) || (state_q == ST_ADDR) ||
                         (state_q == ST_CNT)  || (state_q == ST_DATA);
    assign rx_fire     = rx_valid && rx_ready;
    assign tmo_hit     = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));
    assign adr_nxt     = adr_q + AB'(NB);

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign cpu_n_reset = cpu_n_reset_q;
    assign dbg_mem_op  = mem_op_q;
    assign dbg_wren    = wren_q;
    assign dbg_adr     = dbg_adr_q;
    assign dbg_do      = sh_word;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d       = state_q;
        adr_d         = adr_q;
        hdr_d         = hdr_q;
        cnt_d         = cnt_q;
        is_wr_d       = is_wr_q;
        tmo_d         = tmo_q;
        tim_d         = tim_q;
        cpu_n_reset_d = cpu_n_reset_q;
        tx_valid_d    = tx_valid_q;
        tx_data_d     = tx_data_q;
        reply_d       = reply_q;
        mem_op_d      = mem_op_q;
        wren_d        = wren_q;
        dbg_adr_d     = dbg_adr_q;
        sh_clr        = 1'b0;
        sh_load       = 1'b0;
        sh_in         = 1'b0;
        sh_out        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                hdr_d = '0;
                if (rx_fire) begin
                    state_d = ST_REPLY;
                    reply_d = NAK;
                    case (rx_data)
                        OP_HALT: begin
                            cpu_n_reset_d = 1'b0;
                            reply_d       = ACK;
                        end
                        OP_GO: begin
                            cpu_n_reset_d = 1'b1;
                            reply_d       = ACK;
                        end
                        OP_WRITE, OP_READ: begin
                            // Memory access is refused while the core is running.
                            if (!cpu_n_reset_q) begin
                                is_wr_d = (rx_data == OP_WRITE);
                                state_d = ST_ADDR;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_ADDR: begin
                if (rx_fire) begin
                    adr_d = AB'({rx_data, adr_q} >> 8);
                    hdr_d = hdr_q + 8'd1;
                    tmo_d = '0;
                    if (hdr_q == 8'(ADR_BYTES - 1)) state_d = ST_CNT;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            ST_CNT: begin
                if (rx_fire) begin
                    cnt_d = rx_data;
                    tmo_d = '0;
                    if (is_wr_q) begin
                        sh_clr  = 1'b1;
                        state_d = ST_DATA;
                    end else begin
                        mem_op_d  = 1'b1;
                        dbg_adr_d = adr_q[ADR_W-1:0];
                        tim_d     = '0;
                        state_d   = ST_READ;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            ST_DATA: begin
                if (rx_fire) begin
                    sh_in = 1'b1;
                    tmo_d = '0;
                    if (sh_last) begin
                        mem_op_d  = 1'b1;
                        wren_d    = '1;
                        dbg_adr_d = adr_q[ADR_W-1:0];
                        tim_d     = '0;
                        state_d   = ST_WRITE;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            ST_WRITE: begin
                if (tim_q == 16'(WR_HOLD - 1)) begin
                    mem_op_d = 1'b0;
                    wren_d   = '0;
                    adr_d    = adr_nxt;
                    if (cnt_q == 8'd0) begin
                        reply_d = ACK;
                        state_d = ST_REPLY;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        tmo_d   = '0;
                        state_d = ST_DATA;
                    end
                end else begin
                    tim_d = tim_q + 16'd1;
                end
            end

            ST_READ: begin
                if (tim_q == 16'(RD_LAT - 1)) begin
                    sh_load  = 1'b1;
                    mem_op_d = 1'b0;
                    state_d  = ST_SEND;
                end else begin
                    tim_d = tim_q + 16'd1;
                end
            end

            ST_SEND: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = sh_byte;
                    sh_out     = 1'b1;
                end else if (tx_ready) begin
                    // Counter back at zero while a byte is pending means all NB bytes went out.
                    if (sh_zero) begin
                        tx_valid_d = 1'b0;
                        if (cnt_q == 8'd0) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d     = cnt_q - 8'd1;
                            adr_d     = adr_nxt;
                            mem_op_d  = 1'b1;
                            dbg_adr_d = adr_nxt[ADR_W-1:0];
                            tim_d     = '0;
                            state_d   = ST_READ;
                        end
                    end else begin
                        tx_data_d = sh_byte;
                        sh_out    = 1'b1;
                    end
                end
            end

            ST_REPLY: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = reply_q;
                end else if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q       <= ST_IDLE;
            adr_q         <= '0;
            hdr_q         <= '0;
            cnt_q         <= '0;
            is_wr_q       <= 1'b0;
            tmo_q         <= '0;
            tim_q         <= '0;
            cpu_n_reset_q <= (BOOT_HALTED == 0);
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            reply_q       <= '0;
            mem_op_q      <= 1'b0;
            wren_q        <= '0;
            dbg_adr_q     <= '0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling the
            // pre-edge values computed by the combinational block.
            state_q       <= state_d;
            adr_q         <= adr_d;
            hdr_q         <= hdr_d;
            cnt_q         <= cnt_d;
            is_wr_q       <= is_wr_d;
            tmo_q         <= tmo_d;
            tim_q         <= tim_d;
            cpu_n_reset_q <= cpu_n_reset_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            reply_q       <= reply_d;
            mem_op_q      <= mem_op_d;
            wren_q        <= wren_d;
            dbg_adr_q     <= dbg_adr_d;
        end
    end

endmodule

// File: tb/tb_dbg_mem_loader.sv
// Directed bench for dbg_mem_loader: reset, single/burst/wrapping writes,
// stalled read-back, halt/go/NAK handling, timeout and mid-command reset.
module tb_dbg_mem_loader;

    localparam int DATA_W  = 32;
    localparam int ADR_W   = 32;
    localparam int WR_HOLD = 2;
    localparam int RD_LAT  = 2;
    localparam int TIMEOUT = 40;

    logic              clk = 1'b0;
    logic              n_reset = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b1;
    logic              cpu_n_reset;
    logic              dbg_mem_op;
    logic [3:0]        dbg_wren;
    logic [ADR_W-1:0]  dbg_adr;
    logic [DATA_W-1:0] dbg_do;
    logic [DATA_W-1:0] dbg_di;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  tx_q[$];
    logic [31:0] wr_adr[$];
    logic [31:0] wr_do[$];
    logic [3:0]  wr_wren[$];
    int          wr_len[$];
    int          op_rises = 0;
    int          wr_unstable = 0;
    int          rd_age = 0;
    logic        prev_op = 1'b0;
    logic        prev_wr = 1'b0;

    dbg_mem_loader #(
        .DATA_W(DATA_W), .ADR_W(ADR_W), .ADR_BYTES(4), .WR_HOLD(WR_HOLD),
        .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT), .BOOT_HALTED(1)
    ) dut (
        .clk(clk), .n_reset(n_reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cpu_n_reset(cpu_n_reset), .dbg_mem_op(dbg_mem_op), .dbg_wren(dbg_wren),
        .dbg_adr(dbg_adr), .dbg_do(dbg_do), .dbg_di(dbg_di)
    );

    always #5 clk = ~clk;

    // Read data is only valid once the op has been up for RD_LAT cycles.
    assign dbg_di = (rd_age != RD_LAT) ? 32'hBAD0BAD0 :
                    (dbg_adr == 32'h0002_0004) ? 32'h0005_2583 : 32'h1122_3344;

    always @(negedge clk) begin
        if (dbg_mem_op && !prev_op) op_rises++;
        if (dbg_mem_op && dbg_wren != 4'h0) begin
            if (!prev_wr) begin
                wr_adr.push_back(dbg_adr);
                wr_do.push_back(dbg_do);
                wr_wren.push_back(dbg_wren);
                wr_len.push_back(1);
            end else begin
                wr_len[wr_len.size()-1] = wr_len[wr_len.size()-1] + 1;
                if (dbg_adr !== wr_adr[wr_adr.size()-1] || dbg_do !== wr_do[wr_do.size()-1])
                    wr_unstable++;
            end
        end
        prev_wr = dbg_mem_op && (dbg_wren != 4'h0);
        prev_op = (dbg_mem_op === 1'b1);
        if (dbg_mem_op === 1'b1 && dbg_wren == 4'h0) rd_age++;
        else rd_age = 0;
        if (tx_valid === 1'b1 && tx_ready) tx_q.push_back(tx_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        tx_q.delete();
        wr_adr.delete();
        wr_do.delete();
        wr_wren.delete();
        wr_len.delete();
        op_rises = 0;
        wr_unstable = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            tick();
            n++;
        end
        if (!rx_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_accept: byte %02h not accepted, rx_ready=%b after %0d cycles", b, rx_ready, n);
        end else begin
            tick();
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, input string name);
        int k = 0;
        while (tx_q.size() < n && k < 300) begin
            tick();
            k++;
        end
        vectors++;
        if (tx_q.size() < n) begin
            miscompares++;
            $display("FAIL %s: got %0d tx bytes, expected %0d", name, tx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({cpu_n_reset, dbg_mem_op, dbg_wren, tx_valid, rx_ready} !== 8'b0_0_0000_0_1) begin
            miscompares++;
            $display("FAIL reset_ctrl: cpu=%b op=%b wren=%h txv=%b rxr=%b, expected 0 0 0 0 1",
                     cpu_n_reset, dbg_mem_op, dbg_wren, tx_valid, rx_ready);
        end
        vectors++;
        if (dbg_adr !== 32'h0 || dbg_do !== 32'h0 || tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_data: adr=%h do=%h txd=%h, expected all zero", dbg_adr, dbg_do, tx_data);
        end
        n_reset = 1'b1;
        tick();
        clear_logs();
    endtask

    task automatic test_single_write();
        logic [7:0] s[$];
        clear_logs();
        s = {8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h00};
        foreach (s[i]) send_byte(s[i]);
        vectors++;
        if (dbg_mem_op !== 1'b1 || dbg_wren !== 4'hF) begin
            miscompares++;
            $display("FAIL wr_start: op=%b wren=%h the cycle after last byte, expected 1 F", dbg_mem_op, dbg_wren);
        end
        wait_tx(1, "wr1_ack");
        vectors++;
        if (wr_adr.size() != 1 || wr_adr[0] !== 32'h0 || wr_do[0] !== 32'hAA ||
            wr_wren[0] !== 4'hF || wr_len[0] != WR_HOLD) begin
            miscompares++;
            $display("FAIL wr1: n=%0d adr=%h do=%h wren=%h len=%0d, expected 1 0 AA F %0d",
                     wr_adr.size(), wr_adr[0], wr_do[0], wr_wren[0], wr_len[0], WR_HOLD);
        end
        vectors++;
        if (tx_q[0] !== 8'h06 || wr_unstable != 0) begin
            miscompares++;
            $display("FAIL wr1_reply: tx=%h unstable=%0d, expected 06 0", tx_q[0], wr_unstable);
        end
    endtask

    task automatic test_burst_write();
        logic [7:0]  s[$];
        logic [31:0] ea[3];
        logic [31:0] ed[3];
        clear_logs();
        ea = '{32'h0002_0000, 32'h0002_0004, 32'h0002_0008};
        ed = '{32'h0000_0537, 32'h0005_2583, 32'h0000_006F};
        s = {8'h57, 8'h00, 8'h00, 8'h02, 8'h00, 8'h02,
             8'h37, 8'h05, 8'h00, 8'h00, 8'h83, 8'h25, 8'h05, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        foreach (s[i]) send_byte(s[i]);
        wait_tx(1, "burst_ack");
        repeat (10) tick();
        vectors++;
        if (wr_adr.size() != 3 || op_rises != 3 || tx_q.size() != 1 || tx_q[0] !== 8'h06) begin
            miscompares++;
            $display("FAIL burst_count: writes=%0d ops=%0d tx=%0d, expected 3 3 1 (ack 06)",
                     wr_adr.size(), op_rises, tx_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (wr_adr[i] !== ea[i] || wr_do[i] !== ed[i] || wr_len[i] != WR_HOLD) begin
                miscompares++;
                $display("FAIL burst_w%0d: adr=%h do=%h len=%0d, expected %h %h %0d",
                         i, wr_adr[i], wr_do[i], wr_len[i], ea[i], ed[i], WR_HOLD);
            end
        end
    endtask

    task automatic test_addr_wrap();
        logic [7:0] s[$];
        clear_logs();
        s = {8'h57, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h01,
             8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
        foreach (s[i]) send_byte(s[i]);
        wait_tx(1, "wrap_ack");
        vectors++;
        if (wr_adr.size() != 2 || wr_adr[0] !== 32'hFFFF_FFFC || wr_adr[1] !== 32'h0 ||
            wr_do[1] !== 32'h2222_2222) begin
            miscompares++;
            $display("FAIL wrap: n=%0d adr0=%h adr1=%h do1=%h, expected 2 FFFFFFFC 0 22222222",
                     wr_adr.size(), wr_adr[0], wr_adr[1], wr_do[1]);
        end
    endtask

    task automatic test_read_stall();
        logic [7:0] s[$];
        logic [7:0] held;
        int k = 0;
        int bad = 0;
        clear_logs();
        tx_ready = 1'b0;
        s = {8'h52, 8'h04, 8'h00, 8'h02, 8'h00, 8'h00};
        foreach (s[i]) send_byte(s[i]);
        while (tx_valid !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        held = tx_data;
        repeat (5) begin
            tick();
            if (tx_data !== held || tx_valid !== 1'b1) bad++;
        end
        vectors++;
        if (held !== 8'h83 || bad != 0) begin
            miscompares++;
            $display("FAIL rd_stall: first=%h unstable_cycles=%0d, expected 83 0", held, bad);
        end
        tx_ready = 1'b1;
        wait_tx(4, "rd_bytes");
        repeat (10) tick();
        vectors++;
        if (tx_q.size() != 4 || {tx_q[0], tx_q[1], tx_q[2], tx_q[3]} !== 32'h8325_0500) begin
            miscompares++;
            $display("FAIL rd_data: n=%0d bytes=%h %h %h %h, expected 4 bytes 83 25 05 00",
                     tx_q.size(), tx_q[0], tx_q[1], tx_q[2], tx_q[3]);
        end
        vectors++;
        if (op_rises != 1 || wr_adr.size() != 0) begin
            miscompares++;
            $display("FAIL rd_ops: ops=%0d writes=%0d, expected 1 0", op_rises, wr_adr.size());
        end
    endtask

    task automatic test_go_nak();
        clear_logs();
        send_byte(8'h47);
        vectors++;
        if (cpu_n_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL go_timing: cpu_n_reset=%b cycle after G, expected 1", cpu_n_reset);
        end
        wait_tx(1, "go_ack");
        send_byte(8'h57);
        wait_tx(2, "w_run_nak");
        repeat (10) tick();
        vectors++;
        if (tx_q[0] !== 8'h06 || tx_q[1] !== 8'h15 || op_rises != 0) begin
            miscompares++;
            $display("FAIL go_nak: ack=%h nak=%h ops=%0d, expected 06 15 0", tx_q[0], tx_q[1], op_rises);
        end
        send_byte(8'h11);
        wait_tx(3, "unk_nak");
        vectors++;
        if (tx_q[2] !== 8'h15) begin
            miscompares++;
            $display("FAIL unknown_op: reply=%h, expected 15", tx_q[2]);
        end
        send_byte(8'h48);
        wait_tx(4, "halt_ack");
        vectors++;
        if (tx_q[3] !== 8'h06 || cpu_n_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL halt: reply=%h cpu_n_reset=%b, expected 06 0", tx_q[3], cpu_n_reset);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] s[$];
        clear_logs();
        s = {8'h57, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        foreach (s[i]) send_byte(s[i]);
        repeat (TIMEOUT + 5) tick();
        vectors++;
        if (op_rises != 0 || tx_q.size() != 0 || cpu_n_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_quiet: ops=%0d tx=%0d cpu=%b, expected 0 0 0",
                     op_rises, tx_q.size(), cpu_n_reset);
        end
        send_byte(8'h48);
        wait_tx(1, "timeout_recover");
        vectors++;
        if (tx_q[0] !== 8'h06 || op_rises != 0) begin
            miscompares++;
            $display("FAIL timeout_idle: reply=%h ops=%0d, expected 06 0", tx_q[0], op_rises);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s[$];
        clear_logs();
        s = {8'h57, 8'h00, 8'h00};
        foreach (s[i]) send_byte(s[i]);
        n_reset = 1'b0;
        tick();
        vectors++;
        if (cpu_n_reset !== 1'b0 || tx_valid !== 1'b0 || rx_ready !== 1'b1 || dbg_adr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid: cpu=%b txv=%b rxr=%b adr=%h, expected 0 0 1 0",
                     cpu_n_reset, tx_valid, rx_ready, dbg_adr);
        end
        n_reset = 1'b1;
        tick();
        send_byte(8'h48);
        wait_tx(1, "reset_mid_ack");
        vectors++;
        if (tx_q[0] !== 8'h06) begin
            miscompares++;
            $display("FAIL reset_mid_reply: reply=%h, expected 06", tx_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_write();
        test_addr_wrap();
        test_read_stall();
        test_go_nak();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
